// File: rtl/change_dispenser_if.sv
// Request/status bundle between the vending FSM (master) and the change dispenser (slave).
interface change_dispenser_if;
  logic       start;
  logic [7:0] amount;
  logic       busy;
  logic       done;
  logic [7:0] remaining;
  logic [3:0] coin_cnt;

  modport master (
    output start, amount,
    input  busy, done, remaining, coin_cnt
  );

  modport slave (
    input  start, amount,
    output busy, done, remaining, coin_cnt
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change payout: turns an amount into a train of single-denomination
// dispense pulses (50/20/10/5/1), largest first, gated per item by hopper_ready.
module change_dispenser #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  change_dispenser_if.slave   bus,
  input  logic                hopper_ready,
  output logic                out_money_fifty,
  output logic                out_money_twenty,
  output logic                out_money_ten,
  output logic                out_money_five,
  output logic                out_money_one
);

  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;

  localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    remaining_q;
  logic [3:0]    coin_cnt_q;
  logic          busy_q;
  logic          done_q;
  // One-hot {fifty, twenty, ten, five, one}; doubles as the item being paid.
  logic [4:0]    money_q;
  logic [4:0]    pick;
  logic [7:0]    denom;

  // Largest denomination that still fits in what is left to pay.
  always_comb begin
    pick = 5'b00000;
    if (remaining_q >= 8'd50)      pick = 5'b10000;
    else if (remaining_q >= 8'd20) pick = 5'b01000;
    else if (remaining_q >= 8'd10) pick = 5'b00100;
    else if (remaining_q >= 8'd5)  pick = 5'b00010;
    else if (remaining_q >= 8'd1)  pick = 5'b00001;
  end

  always_comb begin
    denom = 8'd0;
    unique case (money_q)
      5'b10000: denom = 8'd50;
      5'b01000: denom = 8'd20;
      5'b00100: denom = 8'd10;
      5'b00010: denom = 8'd5;
      5'b00001: denom = 8'd1;
      default:  denom = 8'd0;
    endcase
  end

  // remaining is only reduced once the full pulse has gone out, so a reset
  // mid-pulse never counts a truncated item.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      remaining_q <= 8'd0;
      coin_cnt_q  <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      money_q     <= 5'b00000;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            remaining_q <= bus.amount;
            coin_cnt_q  <= 4'd0;
            busy_q      <= 1'b1;
            if (bus.amount != 8'd0) begin
              state <= SELECT;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        SELECT: begin
          if (remaining_q == 8'd0) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else if (hopper_ready) begin
            money_q <= pick;
            cnt     <= '0;
            state   <= PULSE;
          end
        end
        PULSE: begin
          if (cnt == PULSE_LAST) begin
            money_q     <= 5'b00000;
            remaining_q <= remaining_q - denom;
            if (coin_cnt_q != 4'd15) coin_cnt_q <= coin_cnt_q + 4'd1;
            cnt         <= '0;
            state       <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= SELECT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state   <= IDLE;
          busy_q  <= 1'b0;
          money_q <= 5'b00000;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.remaining    = remaining_q;
  assign bus.coin_cnt     = coin_cnt_q;
  assign out_money_fifty  = money_q[4];
  assign out_money_twenty = money_q[3];
  assign out_money_ten    = money_q[2];
  assign out_money_five   = money_q[1];
  assign out_money_one    = money_q[0];

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: scoreboard of expected denominations
// and post-item remaining values, checked by a monitor on every pulse edge.
module tb_change_dispenser;

  localparam int PULSE_CYCLES = 4;
  localparam int GAP_CYCLES   = 4;
  localparam int PERIOD       = PULSE_CYCLES + GAP_CYCLES + 1;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic hopper_ready = 1'b0;
  logic out_money_fifty, out_money_twenty, out_money_ten, out_money_five, out_money_one;

  change_dispenser_if bus ();

  change_dispenser #(.PULSE_CYCLES(PULSE_CYCLES), .GAP_CYCLES(GAP_CYCLES)) dut (
    .sys_clk          (sys_clk),
    .sys_rst_n        (sys_rst_n),
    .bus              (bus),
    .hopper_ready     (hopper_ready),
    .out_money_fifty  (out_money_fifty),
    .out_money_twenty (out_money_twenty),
    .out_money_ten    (out_money_ten),
    .out_money_five   (out_money_five),
    .out_money_one    (out_money_one)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int exp_denom[$];
  int exp_rem[$];
  int cycle = 0;
  int rise_count = 0;
  int done_count = 0;
  int last_rise = 0;
  bit last_rise_valid = 1'b0;
  int width = 0;
  logic [4:0] prev_out = 5'b0;

  function automatic int denom_of(input logic [4:0] v);
    case (v)
      5'b10000: return 50;
      5'b01000: return 20;
      5'b00100: return 10;
      5'b00010: return 5;
      5'b00001: return 1;
      default:  return -1;
    endcase
  endfunction

  // Monitor: pops the scoreboard on every rising/falling edge of a dispense pulse.
  always @(negedge sys_clk) begin
    logic [4:0] cur;
    int exp;
    cycle++;
    cur = {out_money_fifty, out_money_twenty, out_money_ten, out_money_five, out_money_one};
    if (!sys_rst_n) begin
      prev_out = 5'b0;
      width = 0;
    end else begin
      if (bus.done) done_count++;
      if (cur != 5'b0) begin
        checks++;
        if ($countones(cur) != 1) begin
          errors++;
          $display("[TB] FAIL onehot: actual %b, required exactly one bit", cur);
        end
      end
      if (cur != 5'b0 && prev_out == 5'b0) begin
        rise_count++;
        width = 1;
        checks++;
        if (exp_denom.size() == 0) begin
          errors++;
          $display("[TB] FAIL denom: actual %0d, required no pulse", denom_of(cur));
        end else begin
          exp = exp_denom.pop_front();
          if (denom_of(cur) !== exp) begin
            errors++;
            $display("[TB] FAIL denom: actual %0d, required %0d", denom_of(cur), exp);
          end
        end
        if (last_rise_valid) begin
          checks++;
          if (cycle - last_rise !== PERIOD) begin
            errors++;
            $display("[TB] FAIL period: actual %0d, required %0d", cycle - last_rise, PERIOD);
          end
        end
        last_rise = cycle;
        last_rise_valid = 1'b1;
      end else if (cur != 5'b0) begin
        width++;
      end
      if (cur == 5'b0 && prev_out != 5'b0) begin
        checks++;
        if (width !== PULSE_CYCLES) begin
          errors++;
          $display("[TB] FAIL width: actual %0d, required %0d", width, PULSE_CYCLES);
        end
        checks++;
        if (exp_rem.size() == 0) begin
          errors++;
          $display("[TB] FAIL remaining_step: actual %0d, required no item", bus.remaining);
        end else begin
          exp = exp_rem.pop_front();
          if (int'(bus.remaining) !== exp) begin
            errors++;
            $display("[TB] FAIL remaining_step: actual %0d, required %0d", bus.remaining, exp);
          end
        end
      end
      prev_out = cur;
    end
  end

  task automatic issue_start(input logic [7:0] amt);
    @(negedge sys_clk);
    bus.start = 1'b1;
    bus.amount = amt;
    last_rise_valid = 1'b0;
    @(negedge sys_clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge sys_clk);
      if (bus.done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s_done: actual none in %0d cycles, required done pulse", name, budget);
    end
  endtask

  task automatic test_reset;
    @(negedge sys_clk);
    checks++;
    if ({bus.busy, bus.done, out_money_fifty, out_money_twenty, out_money_ten,
         out_money_five, out_money_one} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: actual busy=%b done=%b, required 0", bus.busy, bus.done);
    end
    checks++;
    if (bus.remaining !== 8'd0 || bus.coin_cnt !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_counts: actual rem=%0d cnt=%0d, required 0/0",
               bus.remaining, bus.coin_cnt);
    end
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.remaining !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_release: actual busy=%b rem=%0d, required 0/0",
               bus.busy, bus.remaining);
    end
  endtask

  task automatic test_basic_87;
    int d0;
    hopper_ready = 1'b1;
    exp_denom = '{50, 20, 10, 5, 1, 1};
    exp_rem   = '{37, 17, 7, 2, 1, 0};
    d0 = done_count;
    issue_start(8'd87);
    wait_done(100, "basic87");
    checks++;
    if (bus.coin_cnt !== 4'd6 || bus.remaining !== 8'd0 || bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic87_final: actual cnt=%0d rem=%0d busy=%b, required 6/0/1",
               bus.coin_cnt, bus.remaining, bus.busy);
    end
    @(negedge sys_clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic87_idle: actual busy=%b done=%b, required 0/0", bus.busy, bus.done);
    end
    repeat (3) @(negedge sys_clk);
    checks++;
    if (done_count !== d0 + 1 || exp_denom.size() != 0) begin
      errors++;
      $display("[TB] FAIL basic87_once: actual done=%0d left=%0d, required 1/0",
               done_count - d0, exp_denom.size());
    end
  endtask

  task automatic test_zero;
    int r0;
    r0 = rise_count;
    issue_start(8'd0);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_done: actual done=%b busy=%b, required 1/1", bus.done, bus.busy);
    end
    @(negedge sys_clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || rise_count !== r0) begin
      errors++;
      $display("[TB] FAIL zero_after: actual done=%b busy=%b rises=%0d, required 0/0/0",
               bus.done, bus.busy, rise_count - r0);
    end
  endtask

  task automatic test_max_255;
    exp_denom = '{50, 50, 50, 50, 50, 5};
    exp_rem   = '{205, 155, 105, 55, 5, 0};
    issue_start(8'd255);
    wait_done(100, "max255");
    checks++;
    if (bus.coin_cnt !== 4'd6 || exp_rem.size() != 0) begin
      errors++;
      $display("[TB] FAIL max255_cnt: actual cnt=%0d left=%0d, required 6/0",
               bus.coin_cnt, exp_rem.size());
    end
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_hopper_stall;
    int r0;
    hopper_ready = 1'b0;
    exp_denom = '{20, 10};
    exp_rem   = '{10, 0};
    r0 = rise_count;
    issue_start(8'd30);
    repeat (20) @(negedge sys_clk);
    checks++;
    if (rise_count !== r0 || bus.remaining !== 8'd30 || bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_hold: actual rises=%0d rem=%0d busy=%b, required 0/30/1",
               rise_count - r0, bus.remaining, bus.busy);
    end
    hopper_ready = 1'b1;
    @(negedge sys_clk);
    checks++;
    if (out_money_twenty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_release: actual twenty=%b, required 1", out_money_twenty);
    end
    wait_done(60, "stall");
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_back_to_back;
    exp_denom = '{10, 1, 1};
    exp_rem   = '{2, 1, 0};
    issue_start(8'd12);
    @(negedge sys_clk);
    bus.start = 1'b1;
    bus.amount = 8'd99;
    @(negedge sys_clk);
    bus.start = 1'b0;
    wait_done(60, "b2b");
    checks++;
    if (bus.coin_cnt !== 4'd3 || bus.remaining !== 8'd0) begin
      errors++;
      $display("[TB] FAIL b2b_cnt: actual cnt=%0d rem=%0d, required 3/0",
               bus.coin_cnt, bus.remaining);
    end
    repeat (2) @(negedge sys_clk);
    checks++;
    if (bus.busy !== 1'b0 || exp_denom.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_idle: actual busy=%b left=%0d, required 0/0",
               bus.busy, exp_denom.size());
    end
  endtask

  task automatic test_async_reset;
    int d0;
    bit seen = 1'b0;
    exp_denom = '{50};
    exp_rem.delete();
    d0 = done_count;
    issue_start(8'd50);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge sys_clk);
      if (out_money_fifty) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL areset_pulse: actual no fifty, required fifty within 10 cycles");
    end
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if (out_money_fifty !== 1'b0 || bus.busy !== 1'b0 || bus.remaining !== 8'd0 ||
        bus.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL areset_drop: actual fifty=%b busy=%b rem=%0d done=%b, required 0",
               out_money_fifty, bus.busy, bus.remaining, bus.done);
    end
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    checks++;
    if (done_count !== d0) begin
      errors++;
      $display("[TB] FAIL areset_nodone: actual %0d, required 0", done_count - d0);
    end
    exp_denom = '{5, 1};
    exp_rem   = '{1, 0};
    issue_start(8'd6);
    wait_done(40, "areset_after");
    checks++;
    if (bus.coin_cnt !== 4'd2 || bus.remaining !== 8'd0) begin
      errors++;
      $display("[TB] FAIL areset_after_cnt: actual cnt=%0d rem=%0d, required 2/0",
               bus.coin_cnt, bus.remaining);
    end
    repeat (2) @(negedge sys_clk);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.amount = 8'd0;
    repeat (3) @(negedge sys_clk);
    test_reset();
    test_basic_87();
    test_zero();
    test_max_255();
    test_hopper_stall();
    test_back_to_back();
    test_async_reset();
    checks++;
    if (exp_denom.size() != 0 || exp_rem.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: actual %0d/%0d left, required 0/0",
               exp_denom.size(), exp_rem.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
